// File: rtl/clock_pkg.sv
// Shared alarm-clock constants, FSM state type and time-validation helper.
package clock_pkg;
  localparam int RING_SECONDS   = 60;
  localparam int SNOOZE_SECONDS = 300;
  localparam int MAX_SNOOZES    = 3;
  localparam int MIN_W          = 7;
  localparam int HOUR_W         = 6;
  localparam int TIMER_W        = $clog2(SNOOZE_SECONDS + 1);
  localparam int SNZ_W          = $clog2(MAX_SNOOZES + 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } alarm_state_e;

  function automatic logic time_valid(input logic [MIN_W-1:0] m, input logic [HOUR_W-1:0] h);
    return (m <= MIN_W'(59)) && (h <= HOUR_W'(23));
  endfunction
endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter; load has priority over tick and it saturates at zero.
module sec_countdown #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);
endmodule

// File: rtl/alarm_controller.sv
// Alarm FSM: edge-triggered match against stored time, timed ring, limited snoozes.
module alarm_controller
  import clock_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_alarm,
  input  logic [MIN_W-1:0]  set_minutes,
  input  logic [HOUR_W-1:0] set_hours,
  input  logic [MIN_W-1:0]  cur_minutes,
  input  logic [HOUR_W-1:0] cur_hours,
  input  logic              sec_tick,
  input  logic              alarm_en,
  input  logic              snooze,
  input  logic              stop,
  output logic              alarm_ring,
  output logic              alarm_armed,
  output logic [MIN_W-1:0]  alarm_minutes,
  output logic [HOUR_W-1:0] alarm_hours,
  output logic              set_err
);
  alarm_state_e        state_q, state_d;
  logic [MIN_W-1:0]    alm_min_q;
  logic [HOUR_W-1:0]   alm_hr_q;
  logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
  logic                match_q, ring_q, set_err_q;
  logic                set_ok, match, trigger, expire;
  logic                tmr_load, tmr_zero;
  logic [TIMER_W-1:0]  tmr_load_val, tmr_val;

  assign set_ok  = set_alarm && time_valid(set_minutes, set_hours);
  assign match   = (cur_hours == alm_hr_q) && (cur_minutes == alm_min_q);
  assign trigger = match && !match_q;
  // Expiry fires on the tick that takes the timer from 1 to 0.
  assign expire  = sec_tick && (tmr_zero || (tmr_val == TIMER_W'(1)));

  sec_countdown #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .tick_i     (sec_tick),
    .value_o    (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    snz_cnt_d    = snz_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = TIMER_W'(RING_SECONDS);
    if (!alarm_en) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_d   = ST_RINGING;
            tmr_load  = 1'b1;
            snz_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (set_ok) begin
            state_d   = ST_ARMED;
            snz_cnt_d = '0;
          end else if (stop) begin
            state_d = ST_ARMED;
          end else if (snooze) begin
            if (snz_cnt_q < SNZ_W'(MAX_SNOOZES)) begin
              state_d      = ST_SNOOZE;
              snz_cnt_d    = snz_cnt_q + 1'b1;
              tmr_load     = 1'b1;
              tmr_load_val = TIMER_W'(SNOOZE_SECONDS);
            end else begin
              state_d = ST_ARMED;
            end
          end else if (expire) begin
            state_d = ST_ARMED;
          end
        end
        ST_SNOOZE: begin
          if (set_ok) begin
            state_d   = ST_ARMED;
            snz_cnt_d = '0;
          end else if (stop) begin
            state_d = ST_ARMED;
          end else if (expire) begin
            state_d  = ST_RINGING;
            tmr_load = 1'b1;
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DISARMED;
      alm_min_q <= '0;
      alm_hr_q  <= '0;
      snz_cnt_q <= '0;
      match_q   <= 1'b1;
      ring_q    <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snz_cnt_q <= snz_cnt_d;
      match_q   <= match;
      ring_q    <= (state_d == ST_RINGING);
      set_err_q <= set_alarm && !set_ok;
      if (set_ok) begin
        alm_min_q <= set_minutes;
        alm_hr_q  <= set_hours;
      end
    end
  end

  assign alarm_ring    = ring_q;
  assign alarm_armed   = (state_q == ST_ARMED) || (state_q == ST_SNOOZE);
  assign alarm_minutes = alm_min_q;
  assign alarm_hours   = alm_hr_q;
  assign set_err       = set_err_q;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed scenarios plus a randomized run against a rule-level alarm model.
module tb_alarm_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_alarm = 1'b0, sec_tick = 1'b0, alarm_en = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [6:0] set_minutes = '0, cur_minutes = '0;
  logic [5:0] set_hours = '0, cur_hours = '0;
  logic       alarm_ring, alarm_armed, set_err;
  logic [6:0] alarm_minutes;
  logic [5:0] alarm_hours;

  int checks = 0;
  int passed = 0;
  int fail_lines = 0;

  // Model: mode 0 = off, 1 = waiting for alarm, 2 = sounding, 3 = snoozing
  int m_mode, m_secs, m_snz, m_amin, m_ahr;
  bit m_prev_match, m_err;

  alarm_controller dut (
    .clk(clk), .rst(rst), .set_alarm(set_alarm), .set_minutes(set_minutes),
    .set_hours(set_hours), .cur_minutes(cur_minutes), .cur_hours(cur_hours),
    .sec_tick(sec_tick), .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
    .alarm_ring(alarm_ring), .alarm_armed(alarm_armed), .alarm_minutes(alarm_minutes),
    .alarm_hours(alarm_hours), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_snz = 0; m_amin = 0; m_ahr = 0;
    m_prev_match = 1'b1; m_err = 1'b0;
  endtask

  task automatic model_step();
    int sm, sh, cm, ch;
    bit valid, match, trig;
    sm = int'(set_minutes); sh = int'(set_hours);
    cm = int'(cur_minutes); ch = int'(cur_hours);
    valid = set_alarm && sm <= 59 && sh <= 23;
    match = (cm == m_amin) && (ch == m_ahr);
    trig  = match && !m_prev_match;
    m_prev_match = match;
    m_err = set_alarm && !valid;
    if (!alarm_en) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (trig) begin m_mode = 2; m_secs = 60; m_snz = 0; end
    end else if (m_mode == 2) begin
      if (valid) begin m_mode = 1; m_snz = 0; end
      else if (stop) m_mode = 1;
      else if (snooze) begin
        if (m_snz < 3) begin m_mode = 3; m_snz++; m_secs = 300; end
        else m_mode = 1;
      end else if (sec_tick) begin
        m_secs--;
        if (m_secs == 0) m_mode = 1;
      end
    end else begin
      if (valid) begin m_mode = 1; m_snz = 0; end
      else if (stop) m_mode = 1;
      else if (sec_tick) begin
        m_secs--;
        if (m_secs == 0) begin m_mode = 2; m_secs = 60; end
      end
    end
    if (valid) begin m_amin = sm; m_ahr = sh; end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    set_alarm = 1'b0; snooze = 1'b0; stop = 1'b0; sec_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sec_tick = 1'b1;
      step();
      step();
    end
  endtask

  task automatic fire();
    cur_hours = 6'd2; cur_minutes = 7'd39; step();
    cur_minutes = 7'd40; step();
  endtask

  task automatic load_time(input int h, input int m);
    set_hours = 6'(h); set_minutes = 7'(m); set_alarm = 1'b1; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; model_reset();
    @(posedge clk); #1;
    checks++;
    if ({alarm_ring, alarm_armed, alarm_minutes, alarm_hours, set_err} !== 16'h0)
      $display("FAIL reset_outputs: got %h expected 0000",
               {alarm_ring, alarm_armed, alarm_minutes, alarm_hours, set_err});
    else passed++;
    rst = 1'b0; alarm_en = 1'b1; cur_hours = '0; cur_minutes = '0;
    repeat (3) step();
    checks++;
    if (alarm_ring !== 1'b0 || alarm_armed !== 1'b1)
      $display("FAIL no_trigger_at_midnight: ring=%b armed=%b expected ring=0 armed=1", alarm_ring, alarm_armed);
    else passed++;
  endtask

  task automatic test_ring_duration();
    load_time(2, 40);
    checks++;
    if (alarm_minutes !== 7'd40 || alarm_hours !== 6'd2)
      $display("FAIL load_time: got %0d:%0d expected 2:40", alarm_hours, alarm_minutes);
    else passed++;
    cur_hours = 6'd2; cur_minutes = 7'd39; step();
    checks++;
    if (alarm_ring !== 1'b0) $display("FAIL ring_before_match: ring=%b expected 0", alarm_ring);
    else passed++;
    cur_minutes = 7'd40; step();
    checks++;
    if (alarm_ring !== 1'b1) $display("FAIL ring_after_match: ring=%b expected 1", alarm_ring);
    else passed++;
    ticks(59);
    checks++;
    if (alarm_ring !== 1'b1) $display("FAIL ring_tick59: ring=%b expected 1", alarm_ring);
    else passed++;
    ticks(1);
    checks++;
    if (alarm_ring !== 1'b0 || alarm_armed !== 1'b1)
      $display("FAIL ring_expired: ring=%b armed=%b expected 0/1", alarm_ring, alarm_armed);
    else passed++;
    repeat (5) step();
    checks++;
    if (alarm_ring !== 1'b0) $display("FAIL no_retrigger_same_minute: ring=%b expected 0", alarm_ring);
    else passed++;
  endtask

  task automatic test_snooze();
    fire();
    for (int k = 0; k < 3; k++) begin
      snooze = 1'b1; step();
      checks++;
      if (alarm_ring !== 1'b0 || alarm_armed !== 1'b1)
        $display("FAIL snooze_%0d_silence: ring=%b armed=%b expected 0/1", k, alarm_ring, alarm_armed);
      else passed++;
      ticks(299);
      checks++;
      if (alarm_ring !== 1'b0) $display("FAIL snooze_%0d_tick299: ring=%b expected 0", k, alarm_ring);
      else passed++;
      ticks(1);
      checks++;
      if (alarm_ring !== 1'b1) $display("FAIL snooze_%0d_rering: ring=%b expected 1", k, alarm_ring);
      else passed++;
    end
    snooze = 1'b1; step();
    ticks(300);
    checks++;
    if (alarm_ring !== 1'b0 || alarm_armed !== 1'b1)
      $display("FAIL fourth_snooze_is_stop: ring=%b armed=%b expected 0/1", alarm_ring, alarm_armed);
    else passed++;
  endtask

  task automatic test_stop_no_retrigger();
    cur_minutes = 7'd41; step();
    fire();
    ticks(5);
    stop = 1'b1; step();
    checks++;
    if (alarm_ring !== 1'b0 || alarm_armed !== 1'b1)
      $display("FAIL stop_silence: ring=%b armed=%b expected 0/1", alarm_ring, alarm_armed);
    else passed++;
    repeat (20) step();
    checks++;
    if (alarm_ring !== 1'b0) $display("FAIL stop_no_retrigger: ring=%b expected 0", alarm_ring);
    else passed++;
    cur_minutes = 7'd41; step();
    cur_minutes = 7'd40; step();
    checks++;
    if (alarm_ring !== 1'b1) $display("FAIL next_day_trigger: ring=%b expected 1", alarm_ring);
    else passed++;
    stop = 1'b1; step();
  endtask

  task automatic test_set_err();
    load_time(2, 60);
    checks++;
    if (set_err !== 1'b1 || alarm_minutes !== 7'd40 || alarm_hours !== 6'd2)
      $display("FAIL bad_minutes: err=%b time=%0d:%0d expected err=1 time=2:40", set_err, alarm_hours, alarm_minutes);
    else passed++;
    step();
    checks++;
    if (set_err !== 1'b0) $display("FAIL set_err_one_cycle: err=%b expected 0", set_err);
    else passed++;
    load_time(24, 10);
    checks++;
    if (set_err !== 1'b1 || alarm_minutes !== 7'd40 || alarm_hours !== 6'd2)
      $display("FAIL bad_hours: err=%b time=%0d:%0d expected err=1 time=2:40", set_err, alarm_hours, alarm_minutes);
    else passed++;
  endtask

  task automatic test_disarm_and_reset();
    cur_minutes = 7'd41; step();
    fire();
    alarm_en = 1'b0; step();
    checks++;
    if (alarm_ring !== 1'b0 || alarm_armed !== 1'b0)
      $display("FAIL disable_mid_ring: ring=%b armed=%b expected 0/0", alarm_ring, alarm_armed);
    else passed++;
    alarm_en = 1'b1; step();
    fire();
    snooze = 1'b1; step();
    @(negedge clk); rst = 1'b1; model_reset(); #1;
    checks++;
    if (alarm_ring !== 1'b0 || alarm_armed !== 1'b0 || alarm_minutes !== 7'd0)
      $display("FAIL reset_mid_snooze: ring=%b armed=%b min=%0d expected 0/0/0", alarm_ring, alarm_armed, alarm_minutes);
    else passed++;
    @(posedge clk); #1; rst = 1'b0;
    load_time(2, 40);
    fire();
    @(negedge clk); rst = 1'b1; model_reset(); #1;
    checks++;
    if (alarm_ring !== 1'b0) $display("FAIL reset_mid_ring: ring=%b expected 0", alarm_ring);
    else passed++;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_stop_and_snooze();
    load_time(2, 40);
    step();
    fire();
    stop = 1'b1; snooze = 1'b1; step();
    ticks(300);
    checks++;
    if (alarm_ring !== 1'b0 || alarm_armed !== 1'b1)
      $display("FAIL stop_beats_snooze: ring=%b armed=%b expected 0/1", alarm_ring, alarm_armed);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] exp_v, got_v;
    rst = 1'b1; model_reset();
    @(posedge clk); #1; rst = 1'b0;
    alarm_en = 1'b1; cur_hours = 6'd2; cur_minutes = 7'd39;
    load_time(2, 41);
    for (int i = 0; i < 4000; i++) begin
      alarm_en = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) cur_minutes = 7'(39 + $urandom_range(0, 3));
      sec_tick  = ($urandom_range(0, 3) == 0);
      snooze    = ($urandom_range(0, 59) == 0);
      stop      = ($urandom_range(0, 99) == 0);
      set_alarm = ($urandom_range(0, 249) == 0);
      set_minutes = 7'($urandom_range(39, 61));
      set_hours   = ($urandom_range(0, 4) == 0) ? 6'd24 : 6'd2;
      step();
      exp_v = {m_mode == 2, (m_mode == 1) || (m_mode == 3), 7'(m_amin), 6'(m_ahr), m_err};
      got_v = {alarm_ring, alarm_armed, alarm_minutes, alarm_hours, set_err};
      checks++;
      if (got_v !== exp_v) begin
        if (fail_lines < 10) begin
          $display("FAIL random_cycle_%0d: got %h expected %h", i, got_v, exp_v);
          fail_lines++;
        end
      end else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ring_duration();
    test_snooze();
    test_stop_no_retrigger();
    test_set_err();
    test_disarm_and_reset();
    test_stop_and_snooze();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
